// File: rtl/dmi_arbiter.sv
// dmi_arbiter: shares the debug module's single DMI slave port between the
// JTAG DTM (requester 0) and the on-chip host access path (requester 1).
// One transaction is in flight at a time: IDLE accepts and latches a request,
// ISSUE presents it to the debug module until completion or timeout, and RESP
// returns a one-cycle response strobe to the requester that owns it.
module dmi_arbiter #(
    parameter int ABITS   = 7,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    input  logic [1:0]         req_write_en,
    input  logic [2*ABITS-1:0] req_addr,
    input  logic [63:0]        req_wdata,
    output logic [1:0]         req_ready,
    output logic [1:0]         req_rvalid,
    output logic [31:0]        req_rdata,
    output logic               req_err,
    output logic               dmi_valid,
    output logic               dmi_write_en,
    output logic [ABITS-1:0]   dmi_addr,
    output logic [31:0]        dmi_wdata,
    input  logic               dmi_ready,
    input  logic [31:0]        dmi_rdata,
    output logic               busy,
    output logic               grant_id
);

    // Last ISSUE cycle index; the abort fires while the counter sits here,
    // so dmi_valid is held for exactly TIMEOUT cycles.
    localparam logic [15:0] LAST_CNT = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t            state_reg, state_next;

    // Latched command: the transaction runs from this copy, never from req_*.
    logic              cmd_we_reg;
    logic [ABITS-1:0]  cmd_addr_reg;
    logic [31:0]       cmd_wdata_reg;

    logic              grant_reg;
    logic              rr_last_reg;
    logic [15:0]       cnt_reg;
    logic [31:0]       rdata_reg;
    logic              err_reg;
    logic [1:0]        rvalid_reg;
    logic [1:0]        rvalid_next;

    // Per-requester views of the packed request buses.
    logic [ABITS-1:0]  addr_arr  [2];
    logic [31:0]       wdata_arr [2];
    logic              we_arr    [2];

    logic              any_valid;
    logic              win_id;
    logic              accept;
    logic              capture_ok;
    logic              capture_abort;

    for (genvar gi = 0; gi < 2; gi++) begin : g_req_unpack
        assign addr_arr[gi]  = req_addr[gi*ABITS +: ABITS];
        assign wdata_arr[gi] = req_wdata[gi*32 +: 32];
        assign we_arr[gi]    = req_write_en[gi];
    end

    // Round-robin pick: a lone requester wins outright; on a tie the
    // requester that did not win last time goes first.
    always_comb begin
        any_valid = |req_valid;
        win_id    = 1'b0;
        case (req_valid)
            2'b01:   win_id = 1'b0;
            2'b10:   win_id = 1'b1;
            2'b11:   win_id = ~rr_last_reg;
            default: win_id = 1'b0;
        endcase
    end

    // Next-state and per-cycle strobes of the sequencer.
    always_comb begin
        state_next    = state_reg;
        accept        = 1'b0;
        capture_ok    = 1'b0;
        capture_abort = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (any_valid) begin
                    accept     = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Completion wins over the timeout when both land together.
                if (dmi_ready) begin
                    capture_ok = 1'b1;
                    state_next = ST_RESP;
                end else if (cnt_reg == LAST_CNT) begin
                    capture_abort = 1'b1;
                    state_next    = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Accept strobe and next-cycle response strobe, one bit per requester.
    for (genvar gi = 0; gi < 2; gi++) begin : g_req_strobe
        assign req_ready[gi]   = accept & rst_n & (win_id == 1'(gi));
        assign rvalid_next[gi] = (capture_ok | capture_abort) & (grant_reg == 1'(gi));
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Command, ownership and fairness registers, loaded on acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_we_reg    <= 1'b0;
            cmd_addr_reg  <= '0;
            cmd_wdata_reg <= '0;
            grant_reg     <= 1'b0;
            rr_last_reg   <= 1'b1;
        end else if (accept) begin
            cmd_we_reg    <= we_arr[win_id];
            cmd_addr_reg  <= addr_arr[win_id];
            cmd_wdata_reg <= wdata_arr[win_id];
            grant_reg     <= win_id;
            rr_last_reg   <= win_id;
        end
    end

    // ISSUE-cycle counter; cleared on acceptance, the abort stops it long
    // before it could wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (accept) begin
            cnt_reg <= '0;
        end else if (state_reg == ST_ISSUE) begin
            cnt_reg <= cnt_reg + 16'd1;
        end
    end

    // Response data/error, held until the next completion or abort.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else if (capture_ok) begin
            rdata_reg <= dmi_rdata;
            err_reg   <= 1'b0;
        end else if (capture_abort) begin
            rdata_reg <= 32'h0;
            err_reg   <= 1'b1;
        end
    end

    // One-cycle response strobe, high only during RESP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid_reg <= 2'b00;
        end else begin
            rvalid_reg <= rvalid_next;
        end
    end

    assign dmi_valid    = (state_reg == ST_ISSUE);
    assign dmi_write_en = cmd_we_reg;
    assign dmi_addr     = cmd_addr_reg;
    assign dmi_wdata    = cmd_wdata_reg;
    assign busy         = (state_reg != ST_IDLE);
    assign grant_id     = grant_reg;
    assign req_rvalid   = rvalid_reg;
    assign req_rdata    = rdata_reg;
    assign req_err      = err_reg;

endmodule

// File: doc/dmi_arbiter.md
# dmi_arbiter

Two-master arbiter and sequencer that shares the single DMI slave port of the debug module between the JTAG DTM (requester 0) and the on-chip test/host access path (requester 1). It accepts one request at a time, issues it to the debug module, returns the read data to the winning requester, and aborts any access that stalls past a timeout. It sits directly in front of the debug module's DMI slave port.

## Interface
- ABITS, default `ABITS (7), DMI address width.
- TIMEOUT, default 255, maximum ISSUE cycles before abort (1..65535).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_write_en  in  2  per-requester write (1) / read (0).
- req_addr  in  2*ABITS  per-requester address; requester i at [i*ABITS +: ABITS].
- req_wdata  in  64  per-requester write data; requester i at [i*32 +: 32].
- req_ready  out  2  accept strobe, combinational, at most one bit set.
- req_rvalid  out  2  response strobe, one cycle, registered.
- req_rdata  out  32  response data, shared, valid with req_rvalid.
- req_err  out  1  response is a timeout abort, valid with req_rvalid.
- dmi_valid  out  1  request to the debug module.
- dmi_write_en  out  1  write/read to the debug module.
- dmi_addr  out  ABITS  address to the debug module.
- dmi_wdata  out  32  write data to the debug module.
- dmi_ready  in  1  debug module completion.
- dmi_rdata  in  32  debug module read data, sampled when dmi_ready=1.
- busy  out  1  high in ISSUE and RESP.
- grant_id  out  1  index of the requester owning the current transaction.

## Operation
- States: IDLE, ISSUE, RESP. Reset state is IDLE.
- IDLE: winner = the sole valid requester. If both are valid, the winner is the one not in rr_last. req_ready[winner]=1 combinationally. At the edge the block:
  - latches addr, wdata, and write_en into the command registers;
  - sets grant_id=winner and rr_last=winner;
  - clears the timeout counter;
  - goes to ISSUE.
- With no valid request it stays in IDLE.
- ISSUE: dmi_valid=1 and the dmi_* outputs are driven from the command registers, held stable for the whole state. The counter increments every cycle.
  - dmi_ready=1: capture dmi_rdata into req_rdata (writes capture dmi_rdata as well), req_err=0, go to RESP.
  - dmi_ready=0 and counter==TIMEOUT-1: req_rdata=32'h0, req_err=1, go to RESP. dmi_valid drops.
  - dmi_ready takes priority over timeout in the same cycle.
- RESP: req_rvalid[grant_id]=1 for exactly this cycle. Return to IDLE unconditionally.
- req_rdata and req_err hold their value until the next capture.
- Changes on req_* inputs after acceptance are ignored; the transaction is taken from the latched copy.
- rr_last resets to 1, so requester 0 wins the first tie.
- Counter is 16 bits wide and never wraps, because the abort happens first.
- Reset values: req_ready=0, req_rvalid=0, req_rdata=0, req_err=0, dmi_valid=0, dmi_write_en=0, dmi_addr=0, dmi_wdata=0, busy=0, grant_id=0.
- Reset mid-transaction: rst_n=0 in any state returns to IDLE at the next edge and drops the transaction. No req_rvalid is produced for it, and dmi_valid is 0 in the following cycle.

## Timing
- Accept at edge 0, dmi_valid high in cycle 1.
- With dmi_ready=1 in cycle 1: req_rvalid in cycle 2, IDLE in cycle 3, next accept at the end of cycle 3.
- Minimum period is 3 cycles per transaction; each additional dmi_ready=0 cycle adds 1.
- Timeout: dmi_valid stays high for exactly TIMEOUT cycles, then req_rvalid with req_err=1 arrives in the next cycle.
- The losing requester keeps req_valid asserted and is guaranteed the next grant (fairness bound of one transaction).
- req_ready is never asserted outside IDLE.

## Test plan
- Single read: requester 0 reads addr 0x11, debug module ready returns 0x00000382 → req_ready[0] in cycle 0, dmi_valid in cycle 1, req_rvalid[0] with req_rdata=0x00000382 and req_err=0 in cycle 2.
- Tie: both requesters valid continuously after reset → grants go 0,1,0,1. rvalid bits alternate accordingly, each transaction is 3 cycles apart.
- Write pass-through: requester 1 writes 0x80000001 to addr 0x10 → dmi_write_en=1, dmi_addr=0x10, dmi_wdata=0x80000001 held for the full ISSUE state. req_rvalid[1] is then asserted.
- Stall then timeout: TIMEOUT=4 with dmi_ready held 0 → dmi_valid high for 4 cycles, then req_rvalid with req_err=1 and req_rdata=0. A following request with ready=1 completes normally with req_err=0.
- Input change after accept: requester 0 changes req_addr from 0x04 to 0x38 in cycle 1 → dmi_addr stays 0x04.
- Reset in ISSUE: rst_n low for one cycle while dmi_ready=0 → all outputs return to their reset values, no req_rvalid is produced, and the next request is accepted normally.
